// File: rtl/usb_tx_pkg.sv
// Shared types and defaults for the USB transmit timing logic.
package usb_tx_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      EOP    = 2'd2
   } tx_tmr_state_t;

   localparam int USB_CLKS_PER_BIT = 8;
   localparam int USB_WORD_BITS    = 16;
   localparam int USB_MAX_WORDS    = 32;
   localparam int USB_EOP_BITS     = 2;

   // Counter width for a 0..n-1 range; a range of one still needs one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/usb_mod_counter.sv
// Mod-MAX counter (0..MAX-1) with synchronous clear and enable; flags the terminal count.
module usb_mod_counter
   import usb_tx_pkg::*;
#(
   parameter int MAX = 2
) (
   input  logic clk,
   input  logic n_rst,
   input  logic clear,
   input  logic enable,
   output logic wrap
);

   localparam int W = cnt_width(MAX);
   localparam logic [W-1:0] LAST = W'(MAX - 1);
   localparam logic [W-1:0] ONE  = W'(1);

   logic [W-1:0] count;

   assign wrap = (count == LAST);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable)
         count <= wrap ? '0 : count + ONE;
   end

endmodule

// File: rtl/usb_tx_timer_param.sv
// Bit/word/packet timing for the USB TX path: shift strobe, word and packet strobes, timed EOP.
module usb_tx_timer_param
   import usb_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = USB_CLKS_PER_BIT,
   parameter int WORD_BITS    = USB_WORD_BITS,
   parameter int MAX_WORDS    = USB_MAX_WORDS,
   parameter int EOP_BITS     = USB_EOP_BITS,
   localparam int LW          = $clog2(MAX_WORDS + 1)
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          transmitting,
   input  logic          pkt_start,
   input  logic [LW-1:0] pkt_words,
   input  logic          tx_hold,
   output logic          tx_shift,
   output logic          word_sent,
   output logic          data_sent,
   output logic          eop_active,
   output logic          eop_done,
   output logic          busy,
   output logic [LW-1:0] word_index
);

   localparam logic [LW-1:0] MAX_LEN = LW'(MAX_WORDS);
   localparam logic [LW-1:0] ONE_LW  = LW'(1);

   tx_tmr_state_t state, state_nxt;
   logic [LW-1:0] len, word_cnt, pkt_len;
   logic          clk_wrap, bit_wrap, eop_wrap;
   logic          in_active, in_eop, bit_step;

   assign in_active = (state == ACTIVE);
   assign in_eop    = (state == EOP);
   assign pkt_len   = (pkt_words > MAX_LEN) ? MAX_LEN : pkt_words;
   assign bit_step  = in_active && tx_shift && !tx_hold;

   // Dropping transmitting clears every counter on the next edge.
   usb_mod_counter #(.MAX(CLKS_PER_BIT)) u_clk_cnt (
      .clk    (clk),
      .n_rst  (n_rst),
      .clear  (!transmitting || state == IDLE),
      .enable (1'b1),
      .wrap   (clk_wrap)
   );

   usb_mod_counter #(.MAX(WORD_BITS)) u_bit_cnt (
      .clk    (clk),
      .n_rst  (n_rst),
      .clear  (!transmitting || !in_active),
      .enable (bit_step),
      .wrap   (bit_wrap)
   );

   usb_mod_counter #(.MAX(EOP_BITS)) u_eop_cnt (
      .clk    (clk),
      .n_rst  (n_rst),
      .clear  (!transmitting || !in_eop),
      .enable (in_eop && tx_shift),
      .wrap   (eop_wrap)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state    <= IDLE;
         len      <= '0;
         word_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (!transmitting)
            len <= '0;
         else if (state == IDLE && pkt_start)
            len <= pkt_len;
         if (!transmitting || state == IDLE || eop_done)
            word_cnt <= '0;
         else if (word_sent)
            word_cnt <= word_cnt + ONE_LW;
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      tx_shift  = 1'b0;
      word_sent = 1'b0;
      data_sent = 1'b0;
      eop_done  = 1'b0;

      if (transmitting && state != IDLE)
         tx_shift = clk_wrap;
      word_sent = bit_step && bit_wrap;
      data_sent = word_sent && (word_cnt + ONE_LW == len);
      eop_done  = in_eop && tx_shift && eop_wrap;

      case (state)
         IDLE:    if (pkt_start) state_nxt = (pkt_words != '0) ? ACTIVE : EOP;
         ACTIVE:  if (data_sent) state_nxt = EOP;
         EOP:     if (eop_done)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      if (!transmitting)
         state_nxt = IDLE;
   end

   assign busy       = (state != IDLE);
   assign eop_active = in_eop;
   assign word_index = word_cnt;

endmodule

// File: tb/tb_usb_tx_timer_param.sv
// Scoreboard bench: a per-packet timeline model queues expected strobes; a monitor pops and compares.
module tb_usb_tx_timer_param;

   localparam int C  = 4;
   localparam int WB = 8;
   localparam int EB = 3;
   localparam int MW = 5;
   localparam int LW = $clog2(MW + 1);

   typedef struct {
      int         t;
      logic [2:0] kind;   // {word_sent, data_sent, eop_done}
      int         widx;
   } ev_t;

   logic          clk = 1'b0;
   logic          n_rst = 1'b1;
   logic          transmitting = 1'b0;
   logic          pkt_start = 1'b0;
   logic          tx_hold = 1'b0;
   logic [LW-1:0] pkt_words = '0;
   logic          tx_shift, word_sent, data_sent, eop_active, eop_done, busy;
   logic [LW-1:0] word_index;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   shift_cnt = 0;
   int   eop_cyc_cnt = 0;
   ev_t  exp_q[$];
   ev_t  mon_e;

   usb_tx_timer_param #(
      .CLKS_PER_BIT (C),
      .WORD_BITS    (WB),
      .MAX_WORDS    (MW),
      .EOP_BITS     (EB)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .transmitting (transmitting),
      .pkt_start    (pkt_start),
      .pkt_words    (pkt_words),
      .tx_hold      (tx_hold),
      .tx_shift     (tx_shift),
      .word_sent    (word_sent),
      .data_sent    (data_sent),
      .eop_active   (eop_active),
      .eop_done     (eop_done),
      .busy         (busy),
      .word_index   (word_index)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: samples on the falling edge, pops one expected strobe per observed strobe.
   always @(negedge clk) begin
      if (n_rst) begin
         if (tx_shift)   shift_cnt++;
         if (eop_active) eop_cyc_cnt++;
         if (word_sent || data_sent || eop_done) begin
            if (exp_q.size() == 0)
               check("stray_strobe", int'({word_sent, data_sent, eop_done}), 0);
            else begin
               mon_e = exp_q.pop_front();
               check("strobe_kind", int'({word_sent, data_sent, eop_done}), int'(mon_e.kind));
               check("strobe_cycle", cyc, mon_e.t);
               check("strobe_word_index", int'(word_index), mon_e.widx);
            end
         end
      end
   end

   task automatic push_ev(input int base, input int j, input int cut,
                          input logic [2:0] kind, input int widx);
      ev_t e;
      if (j < cut) begin
         e.t = base + j;
         e.kind = kind;
         e.widx = widx;
         exp_q.push_back(e);
      end
   endtask

   // Called just after a rising edge. Cycle j of the packet is the j-th clock after the start edge;
   // a strobe in cycle j is seen by the monitor when cyc == base + j.
   task automatic run_packet(input int words, input int hold_pct, input int hold_p,
                             input int cut_at, input bit use_rst);
      int len, bits, a_per, total, base, cut, exp_eop;
      bit hold_q[$];
      bit h, aborted;

      len   = (words > MW) ? MW : words;
      cut   = (cut_at > 0) ? cut_at : (1 << 30);
      base  = cyc;
      bits  = 0;
      a_per = 0;
      aborted = 1'b0;

      // Each bit period either carries a data bit or is stretched by a stuff-bit hold.
      while (bits < len * WB) begin
         h = (a_per == hold_p) || ($urandom_range(99) < hold_pct);
         hold_q.push_back(h);
         a_per++;
         if (!h) begin
            bits++;
            if (bits % WB == 0)
               push_ev(base, a_per * C, cut, (bits == len * WB) ? 3'b110 : 3'b100, bits / WB - 1);
         end
      end
      total = (a_per + EB) * C;
      push_ev(base, total, cut, 3'b001, len);

      pkt_start = 1'b1;
      pkt_words = LW'(words);
      tx_hold   = 1'b0;
      @(posedge clk); #1;
      shift_cnt   = 0;
      eop_cyc_cnt = 0;

      for (int j = 1; j <= total; j++) begin
         pkt_start = 1'b0;
         if (j == cut) begin
            if (use_rst) begin
               #1 n_rst = 1'b0;
               #1;
               check("rst_outputs", int'({tx_shift, word_sent, data_sent, eop_active, eop_done, busy}), 0);
               check("rst_word_index", int'(word_index), 0);
               exp_q.delete();
               @(posedge clk); #1 n_rst = 1'b1;
            end else begin
               transmitting = 1'b0;
               @(posedge clk); #1;
            end
            check("abort_busy", int'(busy), 0);
            check("abort_word_index", int'(word_index), 0);
            check("abort_eop_active", int'(eop_active), 0);
            transmitting = 1'b1;
            aborted = 1'b1;
            break;
         end
         tx_hold = ((j - 1) / C < a_per) ? hold_q[(j - 1) / C] : 1'($urandom_range(1));
         if ($urandom_range(15) == 0) begin
            pkt_start = 1'b1;
            pkt_words = LW'($urandom_range(MW + 2));
         end
         @(posedge clk); #1;
      end
      pkt_start = 1'b0;

      if (aborted) begin
         exp_eop = (use_rst ? cut - 1 : cut) - a_per * C;
         check("abort_shift_count", shift_cnt, (cut - 1) / C);
         check("abort_eop_cycles", eop_cyc_cnt, (exp_eop > 0) ? exp_eop : 0);
      end else begin
         check("busy_after_eop", int'(busy), 0);
         check("word_index_after_eop", int'(word_index), 0);
         check("shift_count", shift_cnt, a_per + EB);
         check("eop_cycles", eop_cyc_cnt, EB * C);
      end

      repeat ($urandom_range(1, 4)) begin
         tx_hold = 1'($urandom_range(1));
         @(posedge clk); #1;
      end
      check("queue_drained", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      #2 n_rst = 1'b0;
      transmitting = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", int'({tx_shift, word_sent, data_sent, eop_active, eop_done, busy}), 0);
      check("reset_word_index", int'(word_index), 0);
      n_rst = 1'b1;
      @(posedge clk); #1;
      check("idle_busy", int'(busy), 0);

      run_packet(1, 0, -1, 0, 1'b0);     // single word, no holds
      run_packet(2, 0, -1, 0, 1'b0);     // word strobes at 32 and 64
      run_packet(3, 0, 4, 0, 1'b0);      // hold on 5th shift of word 0
      run_packet(0, 0, -1, 0, 1'b0);     // zero length: EOP only
      run_packet(7, 0, -1, 0, 1'b0);     // clamps to MAX_WORDS
      run_packet(4, 0, -1, 50, 1'b0);    // transmitting dropped mid-packet
      run_packet(3, 10, -1, 40, 1'b1);   // async reset mid-packet
      run_packet(2, 0, -1, 0, 1'b0);     // clean start after reset

      for (int n = 0; n < 30; n++)
         run_packet($urandom_range(MW + 2), $urandom_range(25), -1,
                    ($urandom_range(4) == 0) ? $urandom_range(1, 150) : 0,
                    1'($urandom_range(1)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/usb_tx_timer_param.md
Name: usb_tx_timer_param

Overview:
Parametrised bit/word/packet timing generator for the USB transmit path, replacing the fixed-length TX timer. It generates the per-bit shift strobe, a word-boundary strobe and a packet-complete strobe. It also sequences a timed EOP phase. Packet length is loaded per packet from the TX controller instead of being hard-coded per packet type. Sits between the TX controller FSM and the NRZI/bit-stuff encoder; honours the encoder's stuff-bit hold.

Parameters:
CLKS_PER_BIT, 8, clk cycles per USB bit period (>=2)
WORD_BITS, 16, data bits per word (>=2)
MAX_WORDS, 32, largest packet length in words (>=1)
EOP_BITS, 2, EOP duration in bit periods (>=1)
(derived) LW = $clog2(MAX_WORDS+1), width of length fields

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
transmitting  in  1  TX path enabled; low aborts and clears everything
pkt_start  in  1  one-cycle pulse: begin packet (sampled in IDLE only)
pkt_words  in  LW  packet length in words, sampled with pkt_start
tx_hold  in  1  stuff bit being inserted: current bit period does not advance bit count
tx_shift  out  1  one-cycle strobe at end of every bit period (ACTIVE and EOP)
word_sent  out  1  one-cycle strobe: last bit of a word shifted
data_sent  out  1  one-cycle strobe: last bit of last word shifted
eop_active  out  1  high throughout EOP phase
eop_done  out  1  one-cycle strobe on final cycle of EOP
busy  out  1  high when state != IDLE
word_index  out  LW  number of words completed in current packet

Behaviour:
- Reset (async, n_rst=0): state IDLE; all counters 0; len register 0; every output 0.
- States: IDLE, ACTIVE, EOP (enum in package).
- IDLE: counters held at 0. pkt_start && transmitting: latch len=pkt_words; go ACTIVE if pkt_words!=0, else go EOP directly. pkt_start outside IDLE is ignored.
- clk_cnt (0..CLKS_PER_BIT-1) runs in ACTIVE and EOP, wraps to 0. tx_shift = (clk_cnt==CLKS_PER_BIT-1), combinational from the register. First tx_shift is CLKS_PER_BIT cycles after the state-entry edge.
- bit_cnt (0..WORD_BITS-1): increments on tx_shift && !tx_hold, ACTIVE only. tx_hold with tx_shift: bit period consumed, bit_cnt unchanged, no word_sent.
- word_sent = ACTIVE && tx_shift && !tx_hold && bit_cnt==WORD_BITS-1. Same cycle, combinational. bit_cnt wraps to 0 and word_cnt increments.
- data_sent = word_sent && word_cnt==len-1. Next state EOP; clk_cnt restarts at 0; word_cnt holds final value (word_index==len during EOP).
- EOP: eop_active=1. eop_cnt counts tx_shift pulses. On the EOP_BITS-th tx_shift: eop_done=1 that cycle; next state IDLE; word_index clears.
- EOP length is exactly EOP_BITS*CLKS_PER_BIT cycles. tx_hold is ignored in EOP.
- transmitting=0 in any state: next edge forces IDLE and clears all counters. Strobes are gated low combinationally while transmitting=0, so no partial-packet strobes occur.
- Packet duration with no holds: len*WORD_BITS*CLKS_PER_BIT cycles to data_sent, plus EOP phase. Each hold cycle adds CLKS_PER_BIT.
- pkt_words > MAX_WORDS: clamp len to MAX_WORDS.
- All counter compares use widths sized by $clog2. No truncation warnings permitted.

Decomposition:
- usb_tx_pkg: state enum tx_tmr_state_t (IDLE, ACTIVE, EOP); default constants USB_CLKS_PER_BIT=8, USB_WORD_BITS=16.
- One sub-module: usb_mod_counter #(MAX), a mod-N counter with clear, enable and wrap-flag outputs. Instantiate it for clk_cnt, bit_cnt and eop_cnt. word_cnt is inline.

Test Plan:
- Reset mid-ACTIVE (n_rst low 1 cycle) -> all outputs 0 immediately; busy=0; next pkt_start starts cleanly.
- pkt_words=1, no hold, defaults -> word_sent and data_sent together at cycle 128 after start edge; eop_active 16 cycles; eop_done at cycle 144; busy falls next.
- pkt_words=3, tx_hold high on the 5th tx_shift of word 0 -> word_sent at 136, 264, 392; data_sent at 392 only; word_index 1, 2, 3.
- pkt_words=0 -> straight to EOP; eop_done after 16 cycles; word_sent/data_sent never assert.
- transmitting dropped at cycle 200 of a 4-word packet -> state IDLE next cycle; no further strobes; word_index=0.
- Params CLKS_PER_BIT=4, WORD_BITS=8, EOP_BITS=3, pkt_words=2 -> word_sent at 32, 64; EOP 12 cycles; pkt_start during busy ignored.
